// File: rtl/irq_ctl.sv
// ---------------------------------------------------------------------------
// irq_ctl -- vectored interrupt controller for a 65C02 core.
//
// Takes N_IRQ asynchronous interrupt sources plus one NMI source and turns
// them into the core's IRQ / NMI request lines. Each IRQ channel is maskable
// and can be level- or edge-triggered. Channel 0 has the highest priority.
// The vector address for the requested or serviced channel is driven on
// `vec` so the core can fetch a per-channel handler address.
//
// Ports:
//   clk      CPU clock
//   RST      asynchronous reset, active-low
//   irq_src  raw interrupt requests (async, active-high)
//   nmi_src  raw NMI request (async, rising edge triggers)
//   sel/WE   register window select and write enable
//   A/DI/DO  register address, write data, combinational read data
//   IRQ      interrupt request to core (high while a channel is requested)
//   NMI      NMI request to core, held until nmi_ack
//   irq_ack  one-cycle pulse on IRQ vector fetch
//   nmi_ack  one-cycle pulse on NMI vector fetch
//   vec      vector address: VEC_BASE + 2*channel
//
// Register map (A):
//   0 MASK  RW, 1 = channel enabled
//   1 PEND  read pending; write-1-clears edge-mode bits
//   2 MODE  RW, 1 = edge-triggered
//   3 CUR   read {valid, 4'b0, idx}; any write is end-of-interrupt
// Bits at or above N_IRQ read 0 and ignore writes.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module irq_ctl #(
    parameter int          N_IRQ    = 8,
    parameter logic [15:0] VEC_BASE = 16'hFFC0
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [N_IRQ-1:0] irq_src,
    input  logic             nmi_src,
    input  logic             sel,
    input  logic             WE,
    input  logic [1:0]       A,
    input  logic [7:0]       DI,
    output logic [7:0]       DO,
    output logic             IRQ,
    output logic             NMI,
    input  logic             irq_ack,
    input  logic             nmi_ack,
    output logic [15:0]      vec
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_PEND = 2'd1;
    localparam logic [1:0] ADDR_MODE = 2'd2;
    localparam logic [1:0] ADDR_CUR  = 2'd3;

    // ------------------------------------------------------------------
    // Synchronisers. s3 keeps the previous s2 so edges are detected on
    // already-synchronised data.
    // ------------------------------------------------------------------
    logic [N_IRQ-1:0] irq_s1, irq_s2, irq_s3;
    logic             nmi_s1, nmi_s2, nmi_s3;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            irq_s1 <= '0;
            irq_s2 <= '0;
            irq_s3 <= '0;
            nmi_s1 <= 1'b0;
            nmi_s2 <= 1'b0;
            nmi_s3 <= 1'b0;
        end else begin
            irq_s1 <= irq_src;
            irq_s2 <= irq_s1;
            irq_s3 <= irq_s2;
            nmi_s1 <= nmi_src;
            nmi_s2 <= nmi_s1;
            nmi_s3 <= nmi_s2;
        end
    end

    // ------------------------------------------------------------------
    // Register window decode
    // ------------------------------------------------------------------
    logic wr_en, wr_mask, wr_pend, wr_mode, eoi;

    always_comb begin
        wr_en   = sel & WE;
        wr_mask = wr_en & (A == ADDR_MASK);
        wr_pend = wr_en & (A == ADDR_PEND);
        wr_mode = wr_en & (A == ADDR_MODE);
        eoi     = wr_en & (A == ADDR_CUR);
    end

    logic [N_IRQ-1:0] mask, mode;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            mask <= '0;
            mode <= '0;
        end else begin
            if (wr_mask) mask <= DI[N_IRQ-1:0];
            if (wr_mode) mode <= DI[N_IRQ-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Request arbitration
    // ------------------------------------------------------------------
    state_t           state, state_nxt;
    logic [N_IRQ-1:0] edge_pend, edge_set, eff_req, active;
    logic [N_IRQ-1:0] ack_clr, pend_clr, pend_nxt;
    logic             any_active, take_ack;
    logic [2:0]       winner;

    // Level channels see the synchronised line directly; edge channels see
    // their latched pending bit. PEND reads back exactly this view.
    always_comb begin
        edge_set   = irq_s2 & ~irq_s3 & mode;
        eff_req    = (mode & edge_pend) | (~mode & irq_s2);
        active     = eff_req & mask;
        any_active = |active;
    end

    // Lowest set index wins; scanning downward lets the lowest overwrite.
    always_comb begin
        winner = 3'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (active[i]) winner = 3'(i);
        end
    end

    // Acknowledge only counts while a request is actually on the line; an
    // ack that races a dropped level source leaves nothing to service.
    always_comb begin
        take_ack = (state == REQ) & irq_ack & any_active;
        for (int i = 0; i < N_IRQ; i++) begin
            ack_clr[i] = take_ack & (winner == 3'(i));
        end
    end

    // Set beats clear. Bits of level channels are held at zero so a channel
    // switched back to edge mode never inherits a stale request.
    always_comb begin
        pend_clr = ack_clr;
        if (wr_pend) pend_clr = pend_clr | DI[N_IRQ-1:0];
        pend_nxt = mode & (edge_set | (edge_pend & ~pend_clr));
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) edge_pend <= '0;
        else      edge_pend <= pend_nxt;
    end

    // ------------------------------------------------------------------
    // IRQ FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        IRQ       = 1'b0;
        case (state)
            IDLE: begin
                if (any_active) state_nxt = REQ;
            end
            REQ: begin
                IRQ = 1'b1;
                if (!any_active)  state_nxt = IDLE;
                else if (irq_ack) state_nxt = SVC;
            end
            SVC: begin
                if (eoi) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Channel in service. Captured on the accepted ack, cleared on EOI.
    logic       cur_valid;
    logic [2:0] cur_idx;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            cur_valid <= 1'b0;
            cur_idx   <= 3'd0;
        end else if (take_ack) begin
            cur_valid <= 1'b1;
            cur_idx   <= winner;
        end else if ((state == SVC) && eoi) begin
            cur_valid <= 1'b0;
            cur_idx   <= 3'd0;
        end
    end

    // Vector tracks the live winner until service starts, then freezes on
    // the serviced channel so later arrivals cannot redirect the fetch.
    logic [2:0] vec_idx;

    always_comb begin
        vec_idx = (state == SVC) ? cur_idx : winner;
        vec     = VEC_BASE + {12'd0, vec_idx, 1'b0};
    end

    // ------------------------------------------------------------------
    // NMI latch: a fresh edge wins over a simultaneous acknowledge, and
    // edges while NMI is already up merge into the outstanding request.
    // ------------------------------------------------------------------
    logic nmi_q, nmi_edge;

    always_comb nmi_edge = nmi_s2 & ~nmi_s3;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) nmi_q <= 1'b0;
        else      nmi_q <= nmi_edge | (nmi_q & ~nmi_ack);
    end

    assign NMI = nmi_q;

    // ------------------------------------------------------------------
    // Read mux (zero-extended so unimplemented channels read 0)
    // ------------------------------------------------------------------
    always_comb begin
        DO = 8'h00;
        case (A)
            ADDR_MASK: DO = 8'(mask);
            ADDR_PEND: DO = 8'(eff_req);
            ADDR_MODE: DO = 8'(mode);
            ADDR_CUR:  DO = {cur_valid, 4'b0000, cur_idx};
            default:   DO = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_irq_ctl.sv
// Scoreboard bench for irq_ctl: the stimulus thread queues expected values,
// a monitor thread samples the DUTs on the falling edge and compares.
`timescale 1ns/1ps

module tb_irq_ctl;

    localparam int K_IRQ = 0, K_NMI = 1, K_VEC = 2, K_DO = 3,
                   K_DO3 = 4, K_VEC3 = 5, K_IRQ3 = 6, K_NMI3 = 7;

    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       name;
    } item_t;

    item_t sb[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  irq_src = '0;
    logic [2:0]  irq_src3 = '0;
    logic        nmi_src = 1'b0;
    logic        sel = 1'b0, sel3 = 1'b0, WE = 1'b0;
    logic [1:0]  A = '0;
    logic [7:0]  DI = '0;
    logic        irq_ack = 1'b0, nmi_ack = 1'b0;
    logic [7:0]  DO, DO3;
    logic        IRQ, NMI, IRQ3, NMI3;
    logic [15:0] vec, vec3;

    always #5 clk = ~clk;

    irq_ctl #(.N_IRQ(8), .VEC_BASE(16'hFFC0)) dut (
        .clk(clk), .RST(RST), .irq_src(irq_src), .nmi_src(nmi_src),
        .sel(sel), .WE(WE), .A(A), .DI(DI), .DO(DO),
        .IRQ(IRQ), .NMI(NMI), .irq_ack(irq_ack), .nmi_ack(nmi_ack), .vec(vec)
    );

    irq_ctl #(.N_IRQ(3), .VEC_BASE(16'hFFC0)) dut3 (
        .clk(clk), .RST(RST), .irq_src(irq_src3), .nmi_src(1'b0),
        .sel(sel3), .WE(WE), .A(A), .DI(DI), .DO(DO3),
        .IRQ(IRQ3), .NMI(NMI3), .irq_ack(1'b0), .nmi_ack(1'b0), .vec(vec3)
    );

    // Monitor: drains every expectation queued during the current cycle.
    initial begin
        item_t       it;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                it = sb.pop_front();
                case (it.kind)
                    K_IRQ:   act = {15'd0, IRQ};
                    K_NMI:   act = {15'd0, NMI};
                    K_VEC:   act = vec;
                    K_DO:    act = {8'd0, DO};
                    K_DO3:   act = {8'd0, DO3};
                    K_VEC3:  act = vec3;
                    K_IRQ3:  act = {15'd0, IRQ3};
                    default: act = {15'd0, NMI3};
                endcase
                n_chk++;
                if (act !== it.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic push(input int k, input logic [15:0] e, input string nm);
        item_t t;
        t.kind = k;
        t.exp  = e;
        t.name = nm;
        sb.push_back(t);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit d3, input logic [1:0] a, input logic [7:0] d);
        if (d3) sel3 = 1'b1; else sel = 1'b1;
        WE = 1'b1; A = a; DI = d;
        tick(1);
        sel = 1'b0; sel3 = 1'b0; WE = 1'b0;
    endtask

    task automatic rd(input bit d3, input logic [1:0] a, input logic [7:0] e,
                      input string nm);
        if (d3) sel3 = 1'b1; else sel = 1'b1;
        WE = 1'b0; A = a;
        push(d3 ? K_DO3 : K_DO, {8'd0, e}, nm);
        tick(1);
        sel = 1'b0; sel3 = 1'b0;
    endtask

    task automatic ack_irq();
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick(1);
        push(K_IRQ, 16'h0, "rst_irq");
        push(K_NMI, 16'h0, "rst_nmi");
        push(K_VEC, 16'hFFC0, "rst_vec");
        rd(0, 2'd0, 8'h00, "rst_mask");
        rd(0, 2'd1, 8'h00, "rst_pend");
        rd(0, 2'd2, 8'h00, "rst_mode");
        rd(0, 2'd3, 8'h00, "rst_cur");
        RST = 1'b1;
        tick(2);

        // ---------------- edge priority ----------------
        wr(0, 2'd0, 8'hFF);
        wr(0, 2'd2, 8'hFF);
        irq_src[5] = 1'b1; irq_src[2] = 1'b1;
        tick(1);
        irq_src = '0;
        tick(2);
        push(K_IRQ, 16'h0, "edge_irq_e3");
        tick(1);
        push(K_IRQ, 16'h1, "edge_irq_e4");
        push(K_VEC, 16'hFFC4, "edge_vec_ch2");
        ack_irq();
        push(K_IRQ, 16'h0, "svc_irq_low");
        push(K_VEC, 16'hFFC4, "svc_vec_frozen");
        rd(0, 2'd3, 8'h82, "svc_cur");
        rd(0, 2'd1, 8'h20, "svc_pend");
        wr(0, 2'd3, 8'h00);
        push(K_IRQ, 16'h0, "eoi_idle");
        tick(1);
        push(K_IRQ, 16'h1, "eoi_rereq");
        push(K_VEC, 16'hFFCA, "eoi_vec_ch5");
        ack_irq();
        wr(0, 2'd3, 8'h00);
        tick(1);
        push(K_IRQ, 16'h0, "all_serviced");
        rd(0, 2'd1, 8'h00, "pend_empty");

        // ---------------- level drop ----------------
        wr(0, 2'd2, 8'h00);
        wr(0, 2'd0, 8'h08);
        irq_src[3] = 1'b1;
        tick(2);
        push(K_IRQ, 16'h0, "lvl_irq_e2");
        tick(1);
        push(K_IRQ, 16'h1, "lvl_irq_e3");
        push(K_VEC, 16'hFFC6, "lvl_vec_ch3");
        rd(0, 2'd1, 8'h08, "lvl_pend_view");
        irq_src[3] = 1'b0;
        tick(2);
        push(K_IRQ, 16'h1, "lvl_drop_e2");
        tick(1);
        push(K_IRQ, 16'h0, "lvl_drop_e3");
        rd(0, 2'd3, 8'h00, "lvl_cur_none");

        // ---------------- masking / set-wins ----------------
        wr(0, 2'd0, 8'h00);
        wr(0, 2'd2, 8'hFF);
        irq_src[1] = 1'b1;
        tick(1);
        irq_src[1] = 1'b0;
        tick(2);
        push(K_IRQ, 16'h0, "mask_irq_off");
        rd(0, 2'd1, 8'h02, "mask_pend");
        wr(0, 2'd0, 8'h02);
        push(K_IRQ, 16'h0, "unmask_same");
        tick(1);
        push(K_IRQ, 16'h1, "unmask_next");
        push(K_VEC, 16'hFFC2, "unmask_vec");
        ack_irq();
        wr(0, 2'd3, 8'h00);
        wr(0, 2'd0, 8'h00);
        irq_src[1] = 1'b1;
        tick(1);
        irq_src[1] = 1'b0;
        tick(1);
        wr(0, 2'd1, 8'h02);             // clear lands on the same edge as the set
        rd(0, 2'd1, 8'h02, "set_wins");
        wr(0, 2'd1, 8'h02);
        rd(0, 2'd1, 8'h00, "w1c_clear");

        // ---------------- NMI ----------------
        nmi_src = 1'b1;
        tick(1);
        nmi_src = 1'b0;
        tick(1);
        push(K_NMI, 16'h0, "nmi_e2");
        nmi_src = 1'b1;
        tick(1);
        push(K_NMI, 16'h1, "nmi_e3");
        nmi_src = 1'b0;
        tick(2);
        push(K_NMI, 16'h1, "nmi_collapse");
        nmi_ack = 1'b1;
        tick(1);
        nmi_ack = 1'b0;
        push(K_NMI, 16'h0, "nmi_acked");
        tick(3);
        push(K_NMI, 16'h0, "nmi_no_second");
        nmi_src = 1'b1;
        tick(1);
        nmi_src = 1'b0;
        tick(1);
        nmi_src = 1'b1;
        tick(1);
        push(K_NMI, 16'h1, "nmi_up_again");
        nmi_src = 1'b0;
        tick(1);
        nmi_ack = 1'b1;                  // ack coincides with second edge
        tick(1);
        nmi_ack = 1'b0;
        push(K_NMI, 16'h1, "nmi_edge_beats_ack");
        nmi_ack = 1'b1;
        tick(1);
        nmi_ack = 1'b0;
        push(K_NMI, 16'h0, "nmi_final_ack");

        // ---------------- reset mid-service ----------------
        wr(0, 2'd0, 8'h10);
        irq_src[4] = 1'b1; nmi_src = 1'b1;
        tick(1);
        irq_src = '0; nmi_src = 1'b0;
        tick(2);
        push(K_NMI, 16'h1, "pre_rst_nmi");
        tick(1);
        push(K_IRQ, 16'h1, "pre_rst_irq");
        push(K_VEC, 16'hFFC8, "pre_rst_vec");
        ack_irq();
        rd(0, 2'd3, 8'h84, "pre_rst_cur");
        RST = 1'b0;
        push(K_IRQ, 16'h0, "rst_mid_irq");
        push(K_NMI, 16'h0, "rst_mid_nmi");
        push(K_VEC, 16'hFFC0, "rst_mid_vec");
        rd(0, 2'd3, 8'h00, "rst_mid_cur");
        rd(0, 2'd0, 8'h00, "rst_mid_mask");
        rd(0, 2'd1, 8'h00, "rst_mid_pend");
        RST = 1'b1;
        tick(5);
        push(K_IRQ, 16'h0, "post_rst_irq");
        push(K_NMI, 16'h0, "post_rst_nmi");

        // ---------------- N_IRQ = 3 instance ----------------
        wr(1, 2'd0, 8'hFF);
        rd(1, 2'd0, 8'h07, "n3_mask");
        irq_src3[2] = 1'b1;
        tick(2);
        push(K_IRQ3, 16'h0, "n3_irq_e2");
        tick(1);
        push(K_IRQ3, 16'h1, "n3_irq_e3");
        push(K_VEC3, 16'hFFC4, "n3_vec_ch2");
        push(K_NMI3, 16'h0, "n3_nmi");
        wr(1, 2'd2, 8'hFF);
        rd(1, 2'd2, 8'h07, "n3_mode");

        // drain the scoreboard, bounded
        for (int i = 0; i < 10 && sb.size() > 0; i++) tick(1);
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_ctl.md
Name: irq_ctl

Overview:
- Vectored interrupt controller between peripheral interrupt sources and the 65C02 core's IRQ/NMI inputs.
- Generalises the core's single IRQ line to N_IRQ prioritised channels, each maskable and configurable as level- or edge-triggered.
- Supplies a per-channel vector address to the core and adds NMI edge latching with an acknowledge handshake.
- Exposes a 4-byte memory-mapped register window for mask, pending, mode and current-channel/EOI.

Parameters:
N_IRQ, 8, number of IRQ channels (1..8); channel 0 has the highest priority.
VEC_BASE, 16'hFFC0, vector for channel k is VEC_BASE + 2*k.

Ports:
clk  in  1  CPU clock.
RST  in  1  asynchronous reset, active-low.
irq_src  in  N_IRQ  raw interrupt requests, active-high, asynchronous to clk.
nmi_src  in  1  raw NMI request; rising edge triggers.
sel  in  1  register window select.
WE  in  1  register write enable, qualified by sel.
A  in  2  register address.
DI  in  8  register write data.
DO  out  8  register read data (combinational).
IRQ  out  1  interrupt request to core, active-high.
NMI  out  1  NMI request to core, active-high, held until acknowledged.
irq_ack  in  1  one-cycle pulse from core on IRQ vector fetch.
nmi_ack  in  1  one-cycle pulse from core on NMI vector fetch.
vec  out  16  vector address of the channel being requested or serviced.

Behaviour:
- Synchronisers: irq_src and nmi_src each pass through 2 flops (s1, s2). A third flop s3 holds the previous s2 value for edge detection.
- Edge channel k: pend[k] is set when s2[k] & ~s3[k]. pend[k] is cleared by a PEND write with DI[k]=1, or by irq_ack when k is the winner. If a set and a clear coincide, set wins.
- Level channel k: effective request = s2[k]. pend[k] reads back s2[k] and ignores writes.
- Active set = effective request & MASK. winner = lowest set index.
- Registers (written on clk when sel & WE; read combinationally via A):
  - 0 MASK: RW, 1 = enabled.
  - 1 PEND: read pending; write-1-clears edge bits.
  - 2 MODE: RW, 1 = edge-triggered.
  - 3 CUR: read {valid, 4'b0, idx[2:0]}; any write = EOI.
  - Bits at or above N_IRQ read 0 and ignore writes.
- FSM (state register; IRQ = state==REQ):
  - IDLE: if the active set is non-zero → REQ.
  - REQ: vec follows the current winner each cycle.
    - Active set becomes empty (level source dropped or masked) → IDLE, with no service.
    - irq_ack → SVC: CUR = {1, winner}, vec frozen, winner's edge pend cleared.
  - SVC: IRQ=0. An EOI write → IDLE, clearing CUR.valid. Sources arriving during SVC stay pending.
  - irq_ack outside REQ is ignored.
- NMI: a rising edge of the synchronised nmi_src sets NMI. nmi_ack clears it. If a new edge and nmi_ack arrive in the same cycle, NMI stays 1. Further edges while NMI=1 collapse into one. NMI is independent of the IRQ FSM.
- Latency from the first clk edge that samples irq_src:
  - edge channel: pend at edge 3, IRQ high after edge 4;
  - level channel: IRQ high after edge 3;
  - NMI high after edge 3.
- Reset values: MASK=0, MODE=0, pend=0, sync flops=0, state=IDLE, IRQ=0, NMI=0, CUR=0, vec=VEC_BASE.
- Reset asserted mid-operation returns everything to these values immediately. No pending state survives reset.
- Because the synchronisers reset to 0, a source that is already high when reset releases produces an edge.
- vec computation: VEC_BASE + {winner,1'b0}, as 16-bit wrap-free arithmetic. VEC_BASE must keep the top vector below 16'hFFFA.

Test Plan:
- Edge priority: MASK=8'hFF, MODE=8'hFF; pulse irq_src[5] and irq_src[2] in the same cycle → IRQ=1 after 4 clks, vec=16'hFFC4; irq_ack → CUR=8'h82, PEND=8'h20; EOI → REQ again with vec=16'hFFCA.
- Level drop: MODE=0, MASK=8'h08; hold irq_src[3] high → IRQ=1 after 3 clks, vec=16'hFFC6; drop irq_src[3] before ack → IRQ=0 within 3 clks, state IDLE, CUR=0.
- Masking: MODE=8'hFF, MASK=0; pulse irq_src[1] → PEND=8'h02, IRQ stays 0; write MASK=8'h02 → IRQ=1 on the next clk; write PEND=8'h02 in the same cycle as a new irq_src[1] edge reaches pend → PEND remains 8'h02.
- NMI: pulse nmi_src twice, 2 clks apart → NMI=1 after 3 clks; one nmi_ack → NMI=0, with no second request; a new edge coinciding with nmi_ack → NMI=1.
- Reset mid-service: in SVC with CUR=8'h84, assert RST low → IRQ=0, NMI=0, CUR=0, MASK=0, vec=16'hFFC0 immediately; after release with sources low → IRQ stays 0.
- Parameter sweep with N_IRQ=3: write MASK=8'hFF → MASK reads 8'h07; channel 2 vector = 16'hFFC4.
